vector_sequencer: RTL and testbench

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

---
 rtl/vector_sequencer_pkg.sv | 24 ++
 rtl/vector_sequencer_dwell.sv | 55 +++++
 rtl/vector_sequencer.sv | 129 ++++++++++++
 tb/tb_vector_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_sequencer_pkg
// Description : Shared definitions for the vector sequencer: FSM state
//               encoding, vector count and counter/index widths.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   localparam int unsigned VEC_COUNT = 8;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned CNT_W     = 8;

   // Index of the final vector; reaching it ends the sweep instead of wrapping.
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

endpackage : vector_sequencer_pkg
`default_nettype wire

// File: rtl/vector_sequencer_dwell.sv
`default_nettype none
// ============================================================================
// Module      : dwell_timer
// Description : 8-bit dwell counter. Counts while enabled and wraps to zero
//               on the cycle it reaches DWELL-1, flagging that cycle on tc.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               clear  - synchronous clear (priority over enable)
//               enable - count this cycle
//               tc     - terminal count, high while enable and count==DWELL-1
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer
   import vector_sequencer_pkg::*;
#(
   parameter int unsigned DWELL = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // tc depends only on the register and the (registered-state) enable.
   assign tc = enable && (count_q == TC_VAL);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         if (count_q == TC_VAL) begin
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : dwell_timer
`default_nettype wire

// File: rtl/vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_sequencer
// Description : Sweeps a 3-bit stimulus {A,B,C} through 0..7, holding each
//               vector for DWELL cycles, and captures the two response bits
//               {D,E} of the downstream stage into result at the end of
//               each dwell.
// Ports       : clk    - system clock (rising edge)
//               rst_n  - asynchronous active-low reset
//               start  - sweep request, sampled only in IDLE
//               D, E   - response bits from the downstream stage
//               A,B,C  - stimulus vector (A = MSB)
//               busy   - sweep in progress
//               done   - one-cycle completion pulse
//               result - captured responses, {D,E} of vector i at [2i+1:2i]
// Revision    : 1.0 - initial release
// ============================================================================
module vector_sequencer
   import vector_sequencer_pkg::*;
#(
   parameter int unsigned DWELL = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        D,
   input  logic        E,
   output logic        A,
   output logic        B,
   output logic        C,
   output logic        busy,
   output logic        done,
   output logic [15:0] result
);

   seq_state_t       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      result_q, result_d;
   logic [2:0]       abc_q, abc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             tmr_clear;
   logic             tmr_enable;
   logic             tmr_tc;

   // Holding the counter clear outside RUN guarantees every sweep starts
   // from a zero dwell count.
   assign tmr_enable = (state_q == ST_RUN);
   assign tmr_clear  = (state_q != ST_RUN);

   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (tmr_clear),
      .enable (tmr_enable),
      .tc     (tmr_tc)
   );

   // Next-state logic. Outputs are derived from the next state so that they
   // can be registered and still line up with the state register.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      result_d = result_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_RUN;
               idx_d    = '0;
               result_d = '0;
            end
         end

         ST_RUN: begin
            if (tmr_tc) begin
               result_d[{idx_q, 1'b0} +: 2] = {D, E};
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      abc_d  = (state_d == ST_RUN) ? idx_d : 3'b000;
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         result_q <= '0;
         abc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         abc_q    <= abc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign A      = abc_q[2];
   assign B      = abc_q[1];
   assign C      = abc_q[0];
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule : vector_sequencer
`default_nettype wire

// File: tb/tb_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_sequencer
// Description : Directed self-checking bench. Three sequencer instances with
//               DWELL = 4, 2 and 10, each driving its own downstream stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_sequencer;

   logic        clk;
   logic [2:0]  st;
   logic [2:0]  rn;
   logic [2:0]  a_w, b_w, c_w, d_w, e_w, busy_w, done_w;
   logic [15:0] res_w [3];

   int n_total;
   int n_bad;

   // Units 0 and 1: D = A&B, E = B|C. Unit 2: D = 1, E = 0.
   assign d_w[0] = a_w[0] & b_w[0];
   assign e_w[0] = b_w[0] | c_w[0];
   assign d_w[1] = a_w[1] & b_w[1];
   assign e_w[1] = b_w[1] | c_w[1];
   assign d_w[2] = 1'b1;
   assign e_w[2] = 1'b0;

   vector_sequencer #(.DWELL(4)) u_dut4 (
      .clk(clk), .rst_n(rn[0]), .start(st[0]), .D(d_w[0]), .E(e_w[0]),
      .A(a_w[0]), .B(b_w[0]), .C(c_w[0]), .busy(busy_w[0]), .done(done_w[0]),
      .result(res_w[0])
   );

   vector_sequencer #(.DWELL(2)) u_dut2 (
      .clk(clk), .rst_n(rn[1]), .start(st[1]), .D(d_w[1]), .E(e_w[1]),
      .A(a_w[1]), .B(b_w[1]), .C(c_w[1]), .busy(busy_w[1]), .done(done_w[1]),
      .result(res_w[1])
   );

   vector_sequencer #(.DWELL(10)) u_dut10 (
      .clk(clk), .rst_n(rn[2]), .start(st[2]), .D(d_w[2]), .E(e_w[2]),
      .A(a_w[2]), .B(b_w[2]), .C(c_w[2]), .busy(busy_w[2]), .done(done_w[2]),
      .result(res_w[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] abc(input int u);
      return {a_w[u], b_w[u], c_w[u]};
   endfunction

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits until done is seen; cycles = -1 if the bound expires.
   task automatic wait_done(input int u, input int limit, output int cycles);
      cycles = -1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (done_w[u]) begin
            cycles = i;
            break;
         end
      end
   endtask

   // One full sweep from a single start pulse; checks timing, stepping and result.
   task automatic run_sweep(input int u, input int dw, input logic [15:0] exp_res,
                            input string tag);
      int busy_cnt;
      int done_at;
      int dones;
      int step_err;
      st[u] = 1'b1;
      tick();
      st[u] = 1'b0;
      chk({tag, "_busy_at_start"}, busy_w[u], 1'b1);
      chk({tag, "_res_cleared"}, res_w[u], 16'h0000);
      busy_cnt = 1;
      done_at  = -1;
      dones    = 0;
      step_err = 0;
      for (int n = 1; n <= 8 * dw + 4; n++) begin
         tick();
         if (busy_w[u]) busy_cnt++;
         if (done_w[u]) begin
            dones++;
            if (done_at < 0) done_at = n;
         end
         if (n < 8 * dw && abc(u) != 3'(n / dw)) step_err++;
      end
      chk({tag, "_done_edge"}, done_at, 8 * dw);
      chk({tag, "_busy_cycles"}, busy_cnt, 8 * dw);
      chk({tag, "_done_pulses"}, dones, 1);
      chk({tag, "_abc_steps"}, step_err, 0);
      chk({tag, "_result"}, res_w[u], exp_res);
      chk({tag, "_idle_abc"}, abc(u), 3'b000);
   endtask

   initial begin
      int cyc;
      int found;
      int dones;
      int done_at;
      int busy_err;
      logic b17, b18;
      logic [15:0] r17, r18;

      n_total = 0;
      n_bad   = 0;
      st      = 3'b000;
      rn      = 3'b111;

      // Asynchronous reset, checked before any clock edge.
      #3;
      rn = 3'b000;
      #1;
      for (int u = 0; u < 3; u++) begin
         chk("reset_abc", abc(u), 3'b000);
         chk("reset_busy_done", {busy_w[u], done_w[u]}, 2'b00);
         chk("reset_result", res_w[u], 16'h0000);
      end
      tick();
      tick();
      rn = 3'b111;

      // No sweep without a start.
      busy_err = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         busy_err += int'(busy_w != 3'b000) + int'(done_w != 3'b000);
      end
      chk("idle_after_reset", busy_err, 0);

      run_sweep(0, 4, 16'hF454, "dw4");
      run_sweep(1, 2, 16'hF454, "dw2");
      run_sweep(2, 10, 16'hAAAA, "dw10");

      // Reset unit 0 while it presents vector 5.
      st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (abc(0) == 3'd5) begin
            found = 1;
            break;
         end
      end
      chk("midreset_reach_idx5", found, 1);
      rn[0] = 1'b0;
      #1;
      chk("midreset_abc", abc(0), 3'b000);
      chk("midreset_busy_done", {busy_w[0], done_w[0]}, 2'b00);
      chk("midreset_result", res_w[0], 16'h0000);
      #1;
      rn[0] = 1'b1;
      busy_err = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         busy_err += int'(busy_w[0]);
      end
      chk("midreset_stays_idle", busy_err, 0);
      run_sweep(0, 4, 16'hF454, "post_reset");

      // Start held high across a whole sweep on unit 1 (DWELL=2).
      st[1] = 1'b1;
      tick();
      dones    = 0;
      done_at  = -1;
      busy_err = 0;
      b17 = 1'b1; b18 = 1'b0;
      r17 = '0;   r18 = '1;
      for (int n = 1; n <= 18; n++) begin
         tick();
         if (done_w[1]) begin
            dones++;
            if (done_at < 0) done_at = n;
         end
         if (n <= 15 && !busy_w[1]) busy_err++;
         if (n == 17) begin
            b17 = busy_w[1];
            r17 = res_w[1];
         end
         if (n == 18) begin
            b18 = busy_w[1];
            r18 = res_w[1];
         end
      end
      chk("hold_done_edge", done_at, 16);
      chk("hold_done_pulses", dones, 1);
      chk("hold_busy_run", busy_err, 0);
      chk("hold_idle_busy", b17, 1'b0);
      chk("hold_idle_result", r17, 16'hF454);
      chk("hold_restart_busy", b18, 1'b1);
      chk("hold_restart_cleared", r18, 16'h0000);
      st[1] = 1'b0;
      wait_done(1, 40, cyc);
      chk("hold_second_done_seen", int'(cyc > 0), 1);
      chk("hold_second_result", res_w[1], 16'hF454);

      // Start asserted only during the DONE cycle of unit 2.
      st[2] = 1'b1;
      tick();
      st[2] = 1'b0;
      wait_done(2, 100, cyc);
      chk("dw10_done_edge2", cyc, 80);
      st[2] = 1'b1;
      tick();
      st[2] = 1'b0;
      busy_err = int'(busy_w[2]);
      for (int i = 0; i < 6; i++) begin
         tick();
         busy_err += int'(busy_w[2]) + int'(done_w[2]);
      end
      chk("done_start_ignored", busy_err, 0);
      chk("done_start_result_held", res_w[2], 16'hAAAA);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_vector_sequencer
`default_nettype wire
